// File: rtl/inst_fetch.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, reads the I-cache and fills the IF/ID register.
// Optional counters: define FETCH_PERF_EN to add Perf_miss_cycles / Perf_flush_cnt outputs.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        rst_n,
    input  logic        Stall,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall,
    input  logic        Branch_result_ID,
    input  logic [29:0] PC_Sign_extended_ID,
    input  logic        Jump_ID,
    input  logic        JumptoReg_ID,
    input  logic [31:0] JumpReg_addr_ID,
    output logic [31:0] IR,
    output logic [31:0] PCtoReg_ID,
    output logic        Fetch_stall,
`ifdef FETCH_PERF_EN
    output logic [31:0] Perf_miss_cycles,
    output logic [31:0] Perf_flush_cnt,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_MISS       = 2'd1,
        S_MISS_REDIR = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] pend_q, pend_d;
    logic        ren_q;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Cache handshake: the read is requested whenever ICACHE_ren=1; ICACHE_rdata is the word
    // for ICACHE_addr in any cycle with ICACHE_stall=0, otherwise the address is held unchanged.
    assign ICACHE_ren  = ren_q;
    assign ICACHE_addr = pc_q[31:2];
    assign IR          = ir_q;
    assign PCtoReg_ID  = pc4_q;
    assign Fetch_stall = ICACHE_stall & rst_n;
    assign dbg_state   = state_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign redirect    = JumptoReg_ID | Jump_ID | Branch_result_ID;

    always_comb begin
        target = {pc4_q[31:2] + PC_Sign_extended_ID, 2'b00};
        if (JumptoReg_ID)
            target = JumpReg_addr_ID;
        else if (Jump_ID)
            target = {pc4_q[31:28], ir_q[25:0], 2'b00};
    end

    // Stall freezes the whole stage, FSM included, so a held redirect is simply re-seen later.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        pend_d  = pend_q;
        if (ren_q && !Stall) begin
            case (state_q)
                S_RUN, S_MISS: begin
                    if (ICACHE_stall) begin
                        if (redirect) begin
                            pend_d  = target;
                            state_d = S_MISS_REDIR;
                        end else begin
                            state_d = S_MISS;
                        end
                    end else begin
                        state_d = S_RUN;
                        if (redirect) begin
                            pc_d = target;
                            ir_d = NOP_INSTR;
                        end else begin
                            ir_d  = ICACHE_rdata;
                            pc_d  = pc_plus4;
                            pc4_d = pc_plus4;
                        end
                    end
                end
                S_MISS_REDIR: begin
                    if (!ICACHE_stall) begin
                        ir_d    = NOP_INSTR;
                        pc_d    = pend_q;
                        pend_d  = '0;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            pc4_q   <= '0;
            pend_q  <= '0;
            ren_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            pend_q  <= pend_d;
            ren_q   <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] miss_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        nop_inject;

    assign nop_inject = ren_q && !Stall && !ICACHE_stall &&
                        ((state_q == S_MISS_REDIR) || redirect);
    assign Perf_miss_cycles = miss_cnt_q;
    assign Perf_flush_cnt   = flush_cnt_q;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ICACHE_stall && (miss_cnt_q != 32'hFFFF_FFFF))
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (nop_inject && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table plus randomized run against a reference model.
// Define FETCH_PERF_EN to also check the performance counters.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        Clk;
    logic        rst_n;
    logic        Stall;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic        ICACHE_stall;
    logic        Branch_result_ID;
    logic [29:0] PC_Sign_extended_ID;
    logic        Jump_ID;
    logic        JumptoReg_ID;
    logic [31:0] JumpReg_addr_ID;
    logic [31:0] IR;
    logic [31:0] PCtoReg_ID;
    logic        Fetch_stall;
    logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0] Perf_miss_cycles;
    logic [31:0] Perf_flush_cnt;
`endif

    logic        force_en;
    logic [31:0] force_val;

    int checks;
    int failures;

    inst_fetch dut (
        .Clk                 (Clk),
        .rst_n               (rst_n),
        .Stall               (Stall),
        .ICACHE_ren          (ICACHE_ren),
        .ICACHE_addr         (ICACHE_addr),
        .ICACHE_rdata        (ICACHE_rdata),
        .ICACHE_stall        (ICACHE_stall),
        .Branch_result_ID    (Branch_result_ID),
        .PC_Sign_extended_ID (PC_Sign_extended_ID),
        .Jump_ID             (Jump_ID),
        .JumptoReg_ID        (JumptoReg_ID),
        .JumpReg_addr_ID     (JumpReg_addr_ID),
        .IR                  (IR),
        .PCtoReg_ID          (PCtoReg_ID),
        .Fetch_stall         (Fetch_stall),
`ifdef FETCH_PERF_EN
        .Perf_miss_cycles    (Perf_miss_cycles),
        .Perf_flush_cnt      (Perf_flush_cnt),
`endif
        .dbg_state           (dbg_state)
    );

    // ---------------- clock ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory: each word's contents derive from its own address.
    function automatic logic [31:0] pat(input logic [29:0] a);
        return {2'b01, a};
    endfunction

    assign ICACHE_rdata = force_en ? force_val : pat(ICACHE_addr);

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic cs, input logic br, input logic [29:0] off,
                         input logic j, input logic jr, input logic [31:0] jra,
                         input logic fen, input logic [31:0] fval);
        Stall               = st;
        ICACHE_stall        = cs;
        Branch_result_ID    = br;
        PC_Sign_extended_ID = off;
        Jump_ID             = j;
        JumptoReg_ID        = jr;
        JumpReg_addr_ID     = jra;
        force_en            = fen;
        force_val           = fval;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // The stage either fetches sequentially, takes a redirect with one bubble, or waits on the
    // cache; a redirect seen during a wait is owed and paid out (as a bubble) once the wait ends.
    logic        m_ren;
    logic [31:0] m_pc, m_ir, m_pc4;
    logic        m_owed;
    logic [31:0] m_owed_tgt;
    logic [1:0]  m_state;
    logic [31:0] m_miss, m_flush;

    task automatic model_reset();
        m_ren = 1'b0; m_pc = 32'd0; m_ir = NOP; m_pc4 = 32'd0;
        m_owed = 1'b0; m_owed_tgt = 32'd0; m_state = 2'd0;
        m_miss = 32'd0; m_flush = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic        redir;
        logic [31:0] word;
        redir = JumptoReg_ID || Jump_ID || Branch_result_ID;
        if (JumptoReg_ID)   tgt = JumpReg_addr_ID;
        else if (Jump_ID)   tgt = {m_pc4[31:28], m_ir[25:0], 2'b00};
        else                tgt = {m_pc4[31:2] + PC_Sign_extended_ID, 2'b00};
        word = force_en ? force_val : pat(m_pc[31:2]);
        if (ICACHE_stall) m_miss = m_miss + 1;
        if (!m_ren) begin
            m_ren = 1'b1;
        end else if (!Stall) begin
            if (ICACHE_stall) begin
                if (!m_owed && redir) begin
                    m_owed = 1'b1;
                    m_owed_tgt = tgt;
                end
                m_state = m_owed ? 2'd2 : 2'd1;
            end else begin
                m_state = 2'd0;
                if (m_owed) begin
                    m_ir = NOP; m_pc = m_owed_tgt; m_owed = 1'b0; m_flush = m_flush + 1;
                end else if (redir) begin
                    m_ir = NOP; m_pc = tgt; m_flush = m_flush + 1;
                end else begin
                    m_ir = word; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st, cs, br, j, jr, fen;
        logic [29:0] off;
        logic [31:0] jra, fval;
        logic [31:0] exp_pc, exp_ir, exp_pc4;
        logic [1:0]  exp_state;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic cs, input logic br, input logic [29:0] off,
                                input logic j, input logic jr, input logic [31:0] jra,
                                input logic fen, input logic [31:0] fval,
                                input logic [31:0] epc, input logic [31:0] eir,
                                input logic [31:0] epc4, input logic [1:0] est);
        vec_t v;
        v.st = st; v.cs = cs; v.br = br; v.off = off; v.j = j; v.jr = jr; v.jra = jra;
        v.fen = fen; v.fval = fval; v.exp_pc = epc; v.exp_ir = eir; v.exp_pc4 = epc4;
        v.exp_state = est;
        vecs.push_back(v);
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        force_en = 1'b0;
        force_val = 32'd0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        #3;
        chk("reset_addr", {2'b0, ICACHE_addr}, 32'd0);
        chk("reset_ir", IR, NOP);
        chk("reset_pc4", PCtoReg_ID, 32'd0);
        chk("reset_ren", {31'd0, ICACHE_ren}, 32'd0);
        chk("reset_fstall", {31'd0, Fetch_stall}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);

        //   st cs br off           j  jr jra            fen fval            pc            ir             pc4           st
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h0,        NOP,           32'h0,        0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h4,        32'h4000_0000, 32'h4,        0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h8,        32'h4000_0001, 32'h8,        0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'hC,        32'h4000_0002, 32'hC,        0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h10,       32'h4000_0003, 32'h10,       0);
        add(0, 0, 1, 30'h3FFF_FFFE, 0, 0, 32'd0,        0, 32'd0,          32'h8,        NOP,           32'h10,       0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'hC,        32'h4000_0002, 32'hC,        0);
        add(0, 0, 0, 30'd0,        0, 1, 32'h1000_0000, 0, 32'd0,          32'h1000_0000, NOP,          32'hC,        0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         1, 32'h0800_0040,  32'h1000_0004, 32'h0800_0040, 32'h1000_0004, 0);
        add(0, 0, 0, 30'd0,        1, 0, 32'd0,         0, 32'd0,          32'h1000_0100, NOP,          32'h1000_0004, 0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h1000_0104, 32'h4400_0040, 32'h1000_0104, 0);
        add(0, 0, 0, 30'd0,        1, 1, 32'h200,       0, 32'd0,          32'h200,      NOP,           32'h1000_0104, 0);
        add(0, 0, 0, 30'd0,        0, 1, 32'h20,        0, 32'd0,          32'h20,       NOP,           32'h1000_0104, 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 30'd0,    0, 0, 32'd0,         0, 32'd0,          32'h20,       NOP,           32'h1000_0104, 1);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h24,       32'h4000_0008, 32'h24,       0);
        add(0, 1, 1, 30'd7,        0, 0, 32'd0,         0, 32'd0,          32'h24,       32'h4000_0008, 32'h24,       2);
        for (int i = 0; i < 2; i++)
            add(0, 1, 1, 30'd7,    0, 0, 32'd0,         1, 32'hDEAD_BEEF,  32'h24,       32'h4000_0008, 32'h24,       2);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         1, 32'hDEAD_BEEF,  32'h40,       NOP,           32'h24,       0);
        add(0, 0, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h44,       32'h4000_0010, 32'h44,       0);
        for (int i = 0; i < 2; i++)
            add(1, 0, 1, 30'h3FFF_FFFF, 0, 0, 32'd0,    0, 32'd0,          32'h44,       32'h4000_0010, 32'h44,       0);
        add(0, 0, 1, 30'h3FFF_FFFF, 0, 0, 32'd0,        0, 32'd0,          32'h40,       NOP,           32'h44,       0);
        add(0, 1, 0, 30'd0,        0, 0, 32'd0,         0, 32'd0,          32'h40,       NOP,           32'h44,       1);

        repeat (2) tick();
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].cs, vecs[i].br, vecs[i].off, vecs[i].j, vecs[i].jr,
                  vecs[i].jra, vecs[i].fen, vecs[i].fval);
            #1;
            chk($sformatf("v%0d_fstall", i), {31'd0, Fetch_stall}, {31'd0, vecs[i].cs});
            tick();
            chk($sformatf("v%0d_ren", i), {31'd0, ICACHE_ren}, 32'd1);
            chk($sformatf("v%0d_addr", i), {2'b0, ICACHE_addr}, {2'b0, vecs[i].exp_pc[31:2]});
            chk($sformatf("v%0d_ir", i), IR, vecs[i].exp_ir);
            chk($sformatf("v%0d_pc4", i), PCtoReg_ID, vecs[i].exp_pc4);
            chk($sformatf("v%0d_state", i), {30'd0, dbg_state}, {30'd0, vecs[i].exp_state});
        end
`ifdef FETCH_PERF_EN
        chk("perf_miss_directed", Perf_miss_cycles, 32'd9);
        chk("perf_flush_directed", Perf_flush_cnt, 32'd7);
`endif

        // Reset asserted in the middle of a miss acts immediately.
        drive(1'b0, 1'b1, 1'b0, 30'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midmiss_addr", {2'b0, ICACHE_addr}, 32'd0);
        chk("midmiss_ir", IR, NOP);
        chk("midmiss_pc4", PCtoReg_ID, 32'd0);
        chk("midmiss_ren", {31'd0, ICACHE_ren}, 32'd0);
        chk("midmiss_fstall", {31'd0, Fetch_stall}, 32'd0);
        chk("midmiss_state", {30'd0, dbg_state}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("midmiss_perf_miss", Perf_miss_cycles, 32'd0);
        chk("midmiss_perf_flush", Perf_flush_cnt, 32'd0);
`endif

        // ---------------- randomized run ----------------
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            int          kind;
            int          soff;
            logic        st, cs, br, j, jr;
            logic [31:0] r;
            st = ($urandom_range(0, 7) == 0);
            cs = ($urandom_range(0, 4) == 0);
            kind = (m_ir != NOP && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            br = (kind == 1) || (kind >= 2 && $urandom_range(0, 1) == 1);
            j  = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
            jr = (kind == 3);
            soff = int'($urandom_range(0, 127)) - 64;
            r = $urandom;
            drive(st, cs, br, soff[29:0], j, jr, {r[31:2], 2'b00}, 1'b0, 32'd0);
            #1;
            chk("rnd_fstall", {31'd0, Fetch_stall}, {31'd0, cs});
            model_step();
            tick();
            chk("rnd_ren", {31'd0, ICACHE_ren}, {31'd0, m_ren});
            chk("rnd_addr", {2'b0, ICACHE_addr}, {2'b0, m_pc[31:2]});
            chk("rnd_ir", IR, m_ir);
            chk("rnd_pc4", PCtoReg_ID, m_pc4);
            chk("rnd_state", {30'd0, dbg_state}, {30'd0, m_state});
        end
`ifdef FETCH_PERF_EN
        chk("perf_miss_random", Perf_miss_cycles, m_miss);
        chk("perf_flush_random", Perf_flush_cnt, m_flush);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
